// File: rtl/ras_ckpt.sv
// Return address stack with branch checkpoint/restore: circular buffer of return addresses,
// registered pop result, sticky overflow, and snapshot/repair of the top-of-stack state.
module ras_ckpt #(
    parameter int RAS_ADDRESS = 3,
    parameter int XLEN        = 32
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_addr,
    input  logic                   pop,
    input  logic                   restore,
    input  logic [RAS_ADDRESS-1:0] restore_tos,
    input  logic [RAS_ADDRESS:0]   restore_cnt,
    input  logic [XLEN-1:0]        restore_top,
    output logic [XLEN-1:0]        ret_addr,
    output logic                   ret_valid,
    output logic [RAS_ADDRESS-1:0] ckpt_tos,
    output logic [RAS_ADDRESS:0]   ckpt_cnt,
    output logic [XLEN-1:0]        ckpt_top,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int RAS_LEN = 1 << RAS_ADDRESS;

    localparam logic [RAS_ADDRESS-1:0] TOS_ONE   = RAS_ADDRESS'(1'b1);
    localparam logic [RAS_ADDRESS:0]   CNT_ONE   = (RAS_ADDRESS + 1)'(1'b1);
    localparam logic [RAS_ADDRESS:0]   CNT_ZERO  = {(RAS_ADDRESS + 1){1'b0}};
    localparam logic [RAS_ADDRESS:0]   CNT_MAX   = {1'b1, {RAS_ADDRESS{1'b0}}};
    localparam logic [XLEN-1:0]        ADDR_ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0]        mem_r [RAS_LEN];
    logic [RAS_ADDRESS-1:0] tos_r;
    logic [RAS_ADDRESS:0]   cnt_r;
    logic [XLEN-1:0]        ret_addr_r;
    logic                   ret_valid_r;
    logic                   overflow_r;

    logic [RAS_ADDRESS-1:0] tos_m1_s;
    logic [XLEN-1:0]        top_s;
    logic                   empty_s;
    logic                   full_s;

    logic [RAS_ADDRESS-1:0] tos_nxt_s;
    logic [RAS_ADDRESS:0]   cnt_nxt_s;
    logic [XLEN-1:0]        ret_addr_nxt_s;
    logic                   ret_valid_nxt_s;
    logic                   overflow_nxt_s;

    logic                   wr_en_s;
    logic [RAS_ADDRESS-1:0] wr_idx_s;
    logic [XLEN-1:0]        wr_data_s;

    assign tos_m1_s = tos_r - TOS_ONE;
    assign top_s    = mem_r[tos_m1_s];
    assign empty_s  = (cnt_r == CNT_ZERO);
    assign full_s   = (cnt_r == CNT_MAX);

    // Next-state and single write-port selection; restore has priority over push/pop
    always_comb begin
        tos_nxt_s       = tos_r;
        cnt_nxt_s       = cnt_r;
        ret_addr_nxt_s  = ret_addr_r;
        ret_valid_nxt_s = 1'b0;
        overflow_nxt_s  = overflow_r;
        wr_en_s         = 1'b0;
        wr_idx_s        = tos_r;
        wr_data_s       = push_addr;

        if (restore) begin
            tos_nxt_s = restore_tos;
            if (restore_cnt > CNT_MAX) begin
                cnt_nxt_s = CNT_MAX;
            end else begin
                cnt_nxt_s = restore_cnt;
            end
            wr_en_s   = (restore_cnt != CNT_ZERO);
            wr_idx_s  = restore_tos - TOS_ONE;
            wr_data_s = restore_top;
        end else if (pop && !empty_s) begin
            ret_addr_nxt_s  = top_s;
            ret_valid_nxt_s = 1'b1;
            if (push) begin
                // Call and return together replace the top entry in place
                wr_en_s  = 1'b1;
                wr_idx_s = tos_m1_s;
            end else begin
                tos_nxt_s = tos_m1_s;
                cnt_nxt_s = cnt_r - CNT_ONE;
            end
        end else if (push) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = tos_r;
            tos_nxt_s = tos_r + TOS_ONE;
            if (full_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
            if (pop) begin
                ret_addr_nxt_s = ADDR_ZERO;
            end else begin
                ret_addr_nxt_s = ret_addr_r;
            end
        end else if (pop) begin
            ret_addr_nxt_s = ADDR_ZERO;
        end else begin
            ret_addr_nxt_s = ret_addr_r;
        end
    end

    // Entry storage: one write per cycle, suppressed while in reset
    always_ff @(posedge CLK) begin
        if (reset_n && wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Pointer, occupancy and registered result state
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            tos_r       <= {RAS_ADDRESS{1'b0}};
            cnt_r       <= CNT_ZERO;
            ret_addr_r  <= ADDR_ZERO;
            ret_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            tos_r       <= tos_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ret_addr_r  <= ret_addr_nxt_s;
            ret_valid_r <= ret_valid_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end
    end

    assign ret_addr  = ret_addr_r;
    assign ret_valid = ret_valid_r;
    assign ckpt_tos  = tos_r;
    assign ckpt_cnt  = cnt_r;
    assign ckpt_top  = empty_s ? ADDR_ZERO : top_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt (4 entries, 32-bit): directed scenarios plus random traffic
// against an array/pointer reference model; a negedge monitor checks every cycle's outputs.
module tb_ras_ckpt;

    localparam int LEN = 4;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_addr = 32'h0;
    logic        pop = 1'b0;
    logic        restore = 1'b0;
    logic [1:0]  restore_tos = 2'd0;
    logic [2:0]  restore_cnt = 3'd0;
    logic [31:0] restore_top = 32'h0;
    logic [31:0] ret_addr;
    logic        ret_valid;
    logic [1:0]  ckpt_tos;
    logic [2:0]  ckpt_cnt;
    logic [31:0] ckpt_top;
    logic        full;
    logic        empty;
    logic        overflow;

    ras_ckpt #(.RAS_ADDRESS(2), .XLEN(32)) dut (
        .CLK(CLK), .reset_n(reset_n), .push(push), .push_addr(push_addr), .pop(pop),
        .restore(restore), .restore_tos(restore_tos), .restore_cnt(restore_cnt),
        .restore_top(restore_top), .ret_addr(ret_addr), .ret_valid(ret_valid),
        .ckpt_tos(ckpt_tos), .ckpt_cnt(ckpt_cnt), .ckpt_top(ckpt_top),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        int          tos;
        int          cnt;
        logic [31:0] top;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_mem[LEN];
    int          m_tos = 0;
    int          m_cnt = 0;
    logic [31:0] m_ret = 32'h0;
    logic        m_rv = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // one clock: drive inputs, advance the model, queue the expected post-edge view
    task automatic cycle(input logic rn, input logic ps, input logic pp, input logic rs,
                         input logic [31:0] pa, input logic [1:0] rt, input logic [2:0] rc,
                         input logic [31:0] rtop);
        exp_t e;
        int   top_i;
        reset_n = rn; push = ps; pop = pp; restore = rs; push_addr = pa;
        restore_tos = rt; restore_cnt = rc; restore_top = rtop;
        top_i = (m_tos + LEN - 1) % LEN;
        if (!rn) begin
            m_tos = 0; m_cnt = 0; m_ret = 32'h0; m_rv = 1'b0; m_ovf = 1'b0;
        end else if (rs) begin
            m_tos = int'(rt);
            m_cnt = (int'(rc) > LEN) ? LEN : int'(rc);
            if (rc != 3'd0) m_mem[(int'(rt) + LEN - 1) % LEN] = rtop;
            m_rv = 1'b0;
        end else if (pp && m_cnt > 0) begin
            m_ret = m_mem[top_i];
            m_rv = 1'b1;
            if (ps) m_mem[top_i] = pa;
            else begin
                m_tos = top_i;
                m_cnt = m_cnt - 1;
            end
        end else begin
            m_rv = 1'b0;
            if (pp) m_ret = 32'h0;
            if (ps) begin
                if (m_cnt == LEN) m_ovf = 1'b1;
                else m_cnt = m_cnt + 1;
                m_mem[m_tos] = pa;
                m_tos = (m_tos + 1) % LEN;
            end
        end
        e.rv = m_rv; e.ra = m_ret; e.tos = m_tos; e.cnt = m_cnt; e.ovf = m_ovf;
        e.top = (m_cnt == 0) ? 32'h0 : m_mem[(m_tos + LEN - 1) % LEN];
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        push = 1'b0; pop = 1'b0; restore = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] a);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, a, 2'd0, 3'd0, 32'h0);
    endtask

    task automatic do_pop();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
    endtask

    // monitor: one expected record per clock edge, compared half a cycle later
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("ret_valid", 32'(ret_valid), 32'(e.rv));
            cmp("ret_addr", ret_addr, e.ra);
            cmp("ckpt_tos", 32'(ckpt_tos), 32'(e.tos));
            cmp("ckpt_cnt", 32'(ckpt_cnt), 32'(e.cnt));
            cmp("ckpt_top", ckpt_top, e.top);
            cmp("full", 32'(full), 32'(e.cnt == LEN));
            cmp("empty", 32'(empty), 32'(e.cnt == 0));
            cmp("overflow", 32'(overflow), 32'(e.ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < LEN; i++) m_mem[i] = 32'h0;

        // reset state
        do_reset();
        cmp("rst_empty", 32'(empty), 32'd1);
        cmp("rst_full", 32'(full), 32'd0);
        cmp("rst_top", ckpt_top, 32'h0);

        // LIFO order
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        do_pop(); do_pop(); do_pop();
        cmp("lifo_last", ret_addr, 32'h100);
        cmp("lifo_empty", 32'(empty), 32'd1);

        // overflow wrap
        do_reset();
        for (int i = 1; i <= 5; i++) do_push(32'(i * 16));
        cmp("ovf_full", 32'(full), 32'd1);
        cmp("ovf_flag", 32'(overflow), 32'd1);
        cmp("ovf_cnt", 32'(ckpt_cnt), 32'd4);
        for (int i = 0; i < 4; i++) do_pop();
        cmp("ovf_oldest", ret_addr, 32'h20);
        do_pop();
        cmp("ovf_under_v", 32'(ret_valid), 32'd0);
        cmp("ovf_under_a", ret_addr, 32'h0);

        // push and pop in the same cycle
        do_reset();
        do_push(32'hA); do_push(32'hB);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hC, 2'd0, 3'd0, 32'h0);
        cmp("pp_ret", ret_addr, 32'hB);
        cmp("pp_cnt", 32'(ckpt_cnt), 32'd2);
        do_pop();
        cmp("pp_next", ret_addr, 32'hC);

        // checkpoint and repair
        do_reset();
        do_push(32'h1); do_push(32'h2);
        cmp("ck_top", ckpt_top, 32'h2);
        do_pop(); do_push(32'h9); do_push(32'h8);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 2'd2, 3'd2, 32'h2);
        cmp("ck_tos", 32'(ckpt_tos), 32'd2);
        cmp("ck_cnt", 32'(ckpt_cnt), 32'd2);
        do_pop();
        cmp("ck_pop1", ret_addr, 32'h2);
        do_pop();
        cmp("ck_pop2", ret_addr, 32'h1);

        // restore beats simultaneous push and pop
        do_push(32'h55); do_push(32'h66);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD, 2'd3, 3'd3, 32'h77);
        cmp("rs_valid", 32'(ret_valid), 32'd0);
        cmp("rs_tos", 32'(ckpt_tos), 32'd3);
        cmp("rs_top", ckpt_top, 32'h77);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom);
        end

        // reset beats push and restore
        do_push(32'h123);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h456, 2'd1, 3'd4, 32'h789);
        cmp("rr_empty", 32'(empty), 32'd1);
        cmp("rr_ret", ret_addr, 32'h0);
        cmp("rr_ovf", 32'(overflow), 32'd0);
        do_pop();
        cmp("rr_pop", 32'(ret_valid), 32'd0);

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 Parameter RAS_ADDRESS, default 3, SHALL be log2 of stack depth.
REQ-002 Parameter XLEN, default 32, SHALL be the return-address width.
REQ-003 Derived parameter RAS_LEN = 1<<RAS_ADDRESS SHALL be the entry count.
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 push  in  1  predicted call, push push_addr.
REQ-007 push_addr  in  XLEN  return address to push.
REQ-008 pop  in  1  predicted return, pop top entry.
REQ-009 restore  in  1  mispredict repair, load checkpoint.
REQ-010 restore_tos  in  RAS_ADDRESS  checkpointed top-of-stack pointer.
REQ-011 restore_cnt  in  RAS_ADDRESS+1  checkpointed occupancy.
REQ-012 restore_top  in  XLEN  checkpointed top entry value.
REQ-013 ret_addr  out  XLEN  registered predicted return address.
REQ-014 ret_valid  out  1  registered; ret_addr valid this cycle.
REQ-015 ckpt_tos / ckpt_cnt / ckpt_top  out  RAS_ADDRESS / RAS_ADDRESS+1 / XLEN  current state for branch snapshot.
REQ-016 full, empty  out  1  cnt==RAS_LEN, cnt==0 (combinational from state).
REQ-017 overflow  out  1  sticky; set when a push overwrote a live entry.

Function
REQ-018 Storage SHALL be a circular buffer; tos SHALL index next free slot, top entry at tos-1, all index math modulo RAS_LEN.
REQ-019 Push only: mem[tos]<=push_addr; tos<=tos+1; cnt<=min(cnt+1,RAS_LEN).
REQ-020 Push when full SHALL overwrite oldest entry (wrap), keep cnt=RAS_LEN, set overflow.
REQ-021 Pop only, not empty: ret_addr<=mem[tos-1]; ret_valid<=1; tos<=tos-1; cnt<=cnt-1.
REQ-022 Pop when empty: ret_addr<=0, ret_valid<=0, tos/cnt unchanged.
REQ-023 Push and pop same cycle, not empty: ret_addr<=mem[tos-1], ret_valid<=1, mem[tos-1]<=push_addr; tos, cnt unchanged.
REQ-024 Push and pop same cycle, empty: behaves as push only; ret_valid<=0, ret_addr<=0.
REQ-025 Cycles with no pop (and no restore) SHALL drive ret_valid<=0, ret_addr held.
REQ-026 restore SHALL override push and pop: tos<=restore_tos; cnt<=min(restore_cnt,RAS_LEN); if restore_cnt!=0 mem[restore_tos-1]<=restore_top; ret_valid<=0.
REQ-027 restore SHALL not alter overflow.
REQ-028 ckpt_tos, ckpt_cnt SHALL equal registered tos, cnt at cycle start; ckpt_top SHALL equal mem[tos-1] when cnt!=0, else 0.
REQ-029 Latency: ret_addr/ret_valid SHALL appear one cycle after the pop cycle.
REQ-030 Storage SHALL use one write port and combinational read; write ports SHALL never conflict (one write per cycle).

Reset
REQ-031 reset_n low at a rising edge SHALL set tos=0, cnt=0, ret_addr=0, ret_valid=0, overflow=0; mem contents need not clear.
REQ-032 reset_n SHALL override restore, push and pop in the same cycle.
REQ-033 After reset: empty=1, full=0, ckpt_top=0.

Verification (RAS_ADDRESS=2, XLEN=32)
REQ-034 Push 0x100,0x200,0x300 then 3 pops -> ret_addr 0x300,0x200,0x100 each with ret_valid=1, then empty=1.
REQ-035 Push 0x10..0x50 (5 pushes) -> full=1, overflow=1, cnt=4; 4 pops -> 0x50,0x40,0x30,0x20; 5th pop -> ret_valid=0, ret_addr=0.
REQ-036 Push 0xA, 0xB, then push 0xC with pop same cycle -> ret_addr=0xB, ret_valid=1, cnt=2; next pop -> 0xC.
REQ-037 Push 0x1,0x2; capture ckpt (tos=2,cnt=2,top=0x2); pop, push 0x9,0x8; restore with capture -> tos=2, cnt=2, next pop -> 0x2, then 0x1.
REQ-038 Restore asserted with push and pop same cycle -> push/pop ignored, ret_valid=0 next cycle, state equals restore values.
REQ-039 reset_n low during pushes with restore asserted -> all outputs 0, empty=1, next pop -> ret_valid=0.
